// File: rtl/conv_alu_pkg.sv
// Shared definitions for the conv_alu convolution stage: mode encodings, kernel tables,
// widths and latency. Latency depends on CONV_ALU_GRAY_OUT_EN.
package conv_alu_pkg;

  localparam int unsigned AWIDTH_DEF = 19;
  localparam int unsigned DWIDTH_DEF = 12;
  localparam int unsigned KSIZE_DEF  = 5;
  localparam int unsigned NTAPS      = KSIZE_DEF * KSIZE_DEF;
  localparam int unsigned CENTRE     = (KSIZE_DEF / 2) * KSIZE_DEF + (KSIZE_DEF / 2);

  localparam int unsigned CH_W  = 4;
  localparam int unsigned R_LSB = 8;
  localparam int unsigned G_LSB = 4;
  localparam int unsigned B_LSB = 0;

  localparam int unsigned ACC_W = 13;

`ifdef CONV_ALU_GRAY_OUT_EN
  localparam int unsigned LATENCY = 5;
`else
  localparam int unsigned LATENCY = 4;
`endif

  typedef enum logic [1:0] {
    MODE_IDENT = 2'd0,
    MODE_GAUSS = 2'd1,
    MODE_LAP   = 2'd2,
    MODE_INV   = 2'd3
  } mode_e;

  localparam int GAUSS_COEF [NTAPS] = '{
    1,  4,  6,  4, 1,
    4, 16, 24, 16, 4,
    6, 24, 36, 24, 6,
    4, 16, 24, 16, 4,
    1,  4,  6,  4, 1
  };

  localparam int LAP_COEF [NTAPS] = '{
    -1, -1, -1, -1, -1,
    -1, -1, -1, -1, -1,
    -1, -1, 24, -1, -1,
    -1, -1, -1, -1, -1,
    -1, -1, -1, -1, -1
  };

  // Constant-coefficient product built from shifted copies of the sample; |c| < 64.
  function automatic logic signed [ACC_W-1:0] mul_coef(input logic [CH_W-1:0] x, input int c);
    logic signed [ACC_W-1:0] acc;
    int mag;
    acc = '0;
    mag = (c < 0) ? -c : c;
    for (int b = 0; b < 6; b++) begin
      if (mag[b]) acc = acc + ($signed({{(ACC_W - CH_W){1'b0}}, x}) <<< b);
    end
    return (c < 0) ? -acc : acc;
  endfunction

endpackage

// File: rtl/conv_alu_if.sv
// ALU read/write port bundle between the frame-buffer controller (master) and conv_alu (slave).
interface conv_alu_if import conv_alu_pkg::*; #(
  parameter int unsigned AWIDTH = AWIDTH_DEF,
  parameter int unsigned DWIDTH = DWIDTH_DEF,
  parameter int unsigned KSIZE  = KSIZE_DEF
) ();

  logic                            ren_alu;
  logic [AWIDTH-1:0]               raddr_alu;
  logic [KSIZE*KSIZE*DWIDTH-1:0]   rdata_alu;
  logic [AWIDTH-1:0]               waddr_alu;
  logic [DWIDTH-1:0]               wdata_alu;
  logic                            wen_alu;

  modport master (
    output ren_alu, raddr_alu, rdata_alu,
    input  waddr_alu, wdata_alu, wen_alu
  );

  modport slave (
    input  ren_alu, raddr_alu, rdata_alu,
    output waddr_alu, wdata_alu, wen_alu
  );

endinterface

// File: rtl/conv_tap_sum.sv
// One 4-bit colour channel of the 5x5 kernel: products (S1), row sums (S2), total (S3),
// then combinational normalise/saturate for the S4 register in the parent.
module conv_tap_sum import conv_alu_pkg::*; (
  input  logic                    sys_clk,
  input  mode_e                   mode,
  input  logic [NTAPS*CH_W-1:0]   taps,
  output logic [CH_W-1:0]         result
);

  logic signed [ACC_W-1:0] prod_d [NTAPS];
  logic signed [ACC_W-1:0] prod_q [NTAPS];
  logic signed [ACC_W-1:0] row_d  [KSIZE_DEF];
  logic signed [ACC_W-1:0] row_q  [KSIZE_DEF];
  logic signed [ACC_W-1:0] sum_d, sum_q;
  logic signed [ACC_W-1:0] mag;
  mode_e                   mode_s1_q, mode_s2_q, mode_s3_q;
  logic [CH_W-1:0]         centre_s1_q, centre_s2_q, centre_s3_q;

  always_comb begin
    for (int t = 0; t < NTAPS; t++) begin
      prod_d[t] = (mode == MODE_LAP) ? mul_coef(taps[t*CH_W +: CH_W], LAP_COEF[t])
                                     : mul_coef(taps[t*CH_W +: CH_W], GAUSS_COEF[t]);
    end
  end

  always_comb begin
    for (int r = 0; r < KSIZE_DEF; r++) begin
      row_d[r] = '0;
      for (int c = 0; c < KSIZE_DEF; c++) row_d[r] = row_d[r] + prod_q[r*KSIZE_DEF + c];
    end
    sum_d = '0;
    for (int r = 0; r < KSIZE_DEF; r++) sum_d = sum_d + row_q[r];
  end

  // Datapath only; validity is tracked by the parent, so no reset is needed here.
  always_ff @(posedge sys_clk) begin
    prod_q      <= prod_d;
    mode_s1_q   <= mode;
    centre_s1_q <= taps[CENTRE*CH_W +: CH_W];
    row_q       <= row_d;
    mode_s2_q   <= mode_s1_q;
    centre_s2_q <= centre_s1_q;
    sum_q       <= sum_d;
    mode_s3_q   <= mode_s2_q;
    centre_s3_q <= centre_s2_q;
  end

  always_comb begin
    result = '0;
    mag    = sum_q[ACC_W-1] ? -sum_q : sum_q;
    unique case (mode_s3_q)
      MODE_IDENT: result = centre_s3_q;
      MODE_GAUSS: result = CH_W'(sum_q >>> 8);
      MODE_LAP:   result = (mag > 15) ? 4'hF : mag[CH_W-1:0];
      MODE_INV:   result = 4'hF - centre_s3_q;
    endcase
  end

endmodule

// File: rtl/conv_alu.sv
// 5x5 RGB444 convolution stage: window capture with address dedup, valid/address pipeline
// and write-port registers. Define CONV_ALU_GRAY_OUT_EN for grayscale output (+1 cycle).
module conv_alu import conv_alu_pkg::*; #(
  parameter int unsigned AWIDTH = AWIDTH_DEF,
  parameter int unsigned DWIDTH = DWIDTH_DEF,
  parameter int unsigned KSIZE  = KSIZE_DEF
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  conv_alu_if.slave        bus,
  output logic             busy
);

  localparam int unsigned ST_S3 = 3;
  localparam int unsigned ST_S4 = 4;

  logic                            cap;
  logic                            last_vld_q;
  logic [AWIDTH-1:0]               last_addr_q;
  logic [LATENCY:0]                vld_q;
  logic [AWIDTH-1:0]               addr_q [LATENCY+1];
  logic [KSIZE*KSIZE*DWIDTH-1:0]   win_q;
  mode_e                           mode_q;
  logic [NTAPS*CH_W-1:0]           taps_r, taps_g, taps_b;
  logic [CH_W-1:0]                 res_r, res_g, res_b;
  logic [DWIDTH-1:0]               pix_s4_q;

  // A held read of the same address yields one window; dropping ren re-arms it.
  assign cap = en && bus.ren_alu && (!last_vld_q || (bus.raddr_alu != last_addr_q));

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      last_vld_q  <= 1'b0;
      last_addr_q <= '0;
      vld_q       <= '0;
      mode_q      <= MODE_IDENT;
      pix_s4_q    <= '0;
      for (int i = 0; i <= int'(LATENCY); i++) addr_q[i] <= '0;
    end else begin
      last_vld_q <= bus.ren_alu && (last_vld_q || cap);
      vld_q      <= {vld_q[LATENCY-1:0], cap};
      if (cap) begin
        last_addr_q <= bus.raddr_alu;
        addr_q[0]   <= bus.raddr_alu;
        mode_q      <= mode_e'(mode);
      end
      for (int i = 1; i <= int'(LATENCY); i++) begin
        if (vld_q[i-1]) addr_q[i] <= addr_q[i-1];
      end
      if (vld_q[ST_S3]) pix_s4_q <= {res_r, res_g, res_b};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (cap) win_q <= bus.rdata_alu;
  end

  always_comb begin
    taps_r = '0;
    taps_g = '0;
    taps_b = '0;
    for (int t = 0; t < NTAPS; t++) begin
      taps_r[t*CH_W +: CH_W] = win_q[t*DWIDTH + R_LSB +: CH_W];
      taps_g[t*CH_W +: CH_W] = win_q[t*DWIDTH + G_LSB +: CH_W];
      taps_b[t*CH_W +: CH_W] = win_q[t*DWIDTH + B_LSB +: CH_W];
    end
  end

  conv_tap_sum u_sum_r (.sys_clk(sys_clk), .mode(mode_q), .taps(taps_r), .result(res_r));
  conv_tap_sum u_sum_g (.sys_clk(sys_clk), .mode(mode_q), .taps(taps_g), .result(res_g));
  conv_tap_sum u_sum_b (.sys_clk(sys_clk), .mode(mode_q), .taps(taps_b), .result(res_b));

`ifdef CONV_ALU_GRAY_OUT_EN
  logic [5:0]        y_sum;
  logic [CH_W-1:0]   y;
  logic [DWIDTH-1:0] pix_gray_q;

  always_comb begin
    y_sum = {2'b00, pix_s4_q[R_LSB +: CH_W]} + {1'b0, pix_s4_q[G_LSB +: CH_W], 1'b0}
          + {2'b00, pix_s4_q[B_LSB +: CH_W]};
    y     = CH_W'(y_sum >> 2);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      pix_gray_q <= '0;
    end else if (vld_q[ST_S4]) begin
      pix_gray_q <= {y, y, y};
    end
  end

  assign bus.wdata_alu = pix_gray_q;
`else
  assign bus.wdata_alu = pix_s4_q;
`endif

  assign bus.waddr_alu = addr_q[LATENCY];
  assign bus.wen_alu   = vld_q[LATENCY];
  assign busy          = |vld_q;

endmodule

// File: tb/tb_conv_alu.sv
// Directed scoreboard bench for conv_alu; expected writes are queued at drive time.
module tb_conv_alu;

  localparam int unsigned AW = 19;
  localparam int unsigned DW = 12;
  localparam int unsigned KS = 5;
  localparam int unsigned WW = KS * KS * DW;
`ifdef CONV_ALU_GRAY_OUT_EN
  localparam int unsigned LAT = 5;
`else
  localparam int unsigned LAT = 4;
`endif

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       busy;

  conv_alu_if #(.AWIDTH(AW), .DWIDTH(DW), .KSIZE(KS)) bus_if ();

  conv_alu #(.AWIDTH(AW), .DWIDTH(DW), .KSIZE(KS)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .bus     (bus_if),
    .busy    (busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int unsigned   due;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] mk_win(input logic [DW-1:0] centre, input logic [DW-1:0] other);
    logic [WW-1:0] w;
    for (int t = 0; t < KS * KS; t++) w[t*DW +: DW] = (t == 12) ? centre : other;
    return w;
  endfunction

  function automatic logic [DW-1:0] to_out(input logic [DW-1:0] p);
`ifdef CONV_ALU_GRAY_OUT_EN
    int y;
    y = (int'(p[11:8]) + 2 * int'(p[7:4]) + int'(p[3:0])) >> 2;
    return {y[3:0], y[3:0], y[3:0]};
`else
    return p;
`endif
  endfunction

  // Advance one clock and check the write port at the following falling edge.
  task automatic tick();
    exp_t e;
    @(posedge sys_clk);
    cyc++;
    @(negedge sys_clk);
    if (bus_if.wen_alu === 1'b1) begin
      chk("wen_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wen_cycle", cyc, e.due);
        chk("waddr", 32'(bus_if.waddr_alu), 32'(e.addr));
        chk("wdata", 32'(bus_if.wdata_alu), 32'(e.data));
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      chk("wen_missing", 32'(bus_if.wen_alu), 32'd1);
      e = sb.pop_front();
    end
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [WW-1:0] w, input logic [1:0] m,
                      input bit exp_wr, input logic [DW-1:0] rgb);
    bus_if.ren_alu   = 1'b1;
    bus_if.raddr_alu = a;
    bus_if.rdata_alu = w;
    mode             = m;
    if (exp_wr) sb.push_back('{cyc + 1 + LAT, a, to_out(rgb)});
    tick();
  endtask

  task automatic idle(input int n);
    bus_if.ren_alu = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    logic [DW-1:0] c;
    rst              = 1'b1;
    en               = 1'b0;
    mode             = 2'd0;
    bus_if.ren_alu   = 1'b0;
    bus_if.raddr_alu = '0;
    bus_if.rdata_alu = '0;
    tick();
    tick();
    chk("rst_wen", 32'(bus_if.wen_alu), 32'd0);
    chk("rst_waddr", 32'(bus_if.waddr_alu), 32'd0);
    chk("rst_wdata", 32'(bus_if.wdata_alu), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    en  = 1'b1;
    tick();

    // Identity, single strobe
    send(19'd1000, mk_win(12'hABC, 12'h000), 2'd0, 1'b1, 12'hABC);
    chk("busy_active", 32'(busy), 32'd1);
    idle(LAT + 2);
    chk("busy_idle", 32'(busy), 32'd0);

    // Kernel arithmetic, back to back
    send(19'd2000, mk_win(12'h777, 12'h777), 2'd1, 1'b1, 12'h777);
    send(19'd2001, mk_win(12'hF00, 12'h000), 2'd1, 1'b1, 12'h200);
    send(19'd2002, mk_win(12'h555, 12'h555), 2'd2, 1'b1, 12'h000);
    send(19'd2003, mk_win(12'hF00, 12'h000), 2'd2, 1'b1, 12'hF00);
    send(19'd2004, mk_win(12'h000, 12'h00F), 2'd2, 1'b1, 12'h00F);
    send(19'd2005, mk_win(12'h123, 12'h456), 2'd3, 1'b1, 12'hEDC);
    send(19'd2006, mk_win(12'h000, 12'hFFF), 2'd3, 1'b1, 12'hFFF);
    send(19'd0,    mk_win(12'h0F0, 12'hFFF), 2'd0, 1'b1, 12'h0F0);
    idle(LAT + 2);

    // Held address produces one write, then a stream with mode changing per window
    send(19'd42, mk_win(12'h321, 12'h000), 2'd0, 1'b1, 12'h321);
    repeat (9) send(19'd42, mk_win(12'h321, 12'h000), 2'd0, 1'b0, 12'h000);
    for (int a = 0; a < 8; a++) begin
      c = 12'h1A3 + 12'(a) * 12'h111;
      send(AW'(a), mk_win(c, 12'($urandom)), 2'(a[0] ? 3 : 0), 1'b1,
           a[0] ? (12'hFFF ^ c) : c);
    end
    idle(1);
    send(19'd7, mk_win(12'h9C4, 12'h000), 2'd0, 1'b1, 12'h9C4);
    idle(LAT + 2);

    // Enable gates capture only
    send(19'd100, mk_win(12'h111, 12'h000), 2'd0, 1'b1, 12'h111);
    send(19'd101, mk_win(12'h222, 12'h000), 2'd0, 1'b1, 12'h222);
    en = 1'b0;
    for (int a = 102; a < 106; a++) send(AW'(a), mk_win(12'h333, 12'h000), 2'd0, 1'b0, 12'h000);
    bus_if.ren_alu = 1'b0;
    en = 1'b1;
    idle(LAT + 2);

    // Reset with windows in flight
    send(19'd300, mk_win(12'h444, 12'h000), 2'd0, 1'b0, 12'h000);
    send(19'd301, mk_win(12'h555, 12'h000), 2'd0, 1'b0, 12'h000);
    send(19'd302, mk_win(12'h666, 12'h000), 2'd0, 1'b0, 12'h000);
    idle(1);
    rst = 1'b1;
    tick();
    chk("rst_mid_wen", 32'(bus_if.wen_alu), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    idle(LAT + 2);

    send(19'h7FFFF, mk_win(12'h000, 12'h000), 2'd3, 1'b1, 12'hFFF);
    idle(LAT + 3);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_alu.md
Name: conv_alu

Overview:
- Processing stage directly downstream of the frame-buffer memory controller.
- Accepts one KSIZE x KSIZE RGB444 pixel window per new read address and applies a selectable fixed 5x5 kernel per colour channel.
- Writes the result back through the controller's ALU write port (waddr_alu / wdata_alu / wen_alu) into the full frame buffer.
- Fully pipelined: one window accepted per sys_clk cycle, fixed latency.

Parameters:
- AWIDTH, 19, frame-buffer address width
- DWIDTH, 12, pixel width, format {R[11:8],G[7:4],B[3:0]}
- KSIZE, 5, kernel edge length; only 5 is supported

Ports:
- sys_clk  in  1  system clock, single clock domain
- rst  in  1  synchronous, active-high reset
- en  in  1  processing enable; gates window capture only
- mode  in  2  kernel select: 0 identity, 1 Gaussian, 2 Laplacian edge, 3 invert
- ren_alu  in  1  window valid from memory controller
- raddr_alu  in  AWIDTH  frame address of the window centre
- rdata_alu  in  KSIZE*KSIZE*DWIDTH  window; tap (r,c) at [(r*KSIZE+c)*DWIDTH +: DWIDTH], r=0 top row, c=0 left
- waddr_alu  out  AWIDTH  result write address
- wdata_alu  out  DWIDTH  result pixel
- wen_alu  out  1  one-cycle write strobe
- busy  out  1  high while any pipeline stage holds a valid window

Behaviour:
- Reset: waddr_alu=0, wdata_alu=0, wen_alu=0, busy=0; all stage valids and last_addr cleared.
- Capture (stage S0):
  - A window is captured when en && ren_alu && (!last_vld || raddr_alu != last_addr).
  - last_addr and last_vld are updated on every capture. last_vld clears whenever ren_alu=0.
  - A held ren_alu with an unchanged address therefore produces exactly one result.
- Latched with each capture: window, address, mode. A mode change mid-stream affects only later captures.
- Pipeline:
  - S1: per-tap coefficient products via shift-add, no multipliers.
  - S2: five row sums.
  - S3: total sum.
  - S4: normalise/saturate, then register the outputs.
  - wen_alu rises exactly 4 cycles after the capture cycle and lasts one cycle. waddr_alu equals the captured raddr_alu.
- Arithmetic, per channel, on a 4-bit unsigned sample:
  - 13-bit signed accumulators throughout.
  - Mode 0: output = centre tap (2,2).
  - Mode 1: coefficient = outer product of [1 4 6 4 1] (sum 256); output = sum>>8, truncating.
  - Mode 2: centre coefficient +24, all others -1; output = |sum| saturated to 15.
  - Mode 3: output = 15 - centre tap.
- Back-to-back captures every cycle yield back-to-back wen_alu pulses with no bubbles.
- en deasserted: no new captures; in-flight windows complete and write normally.
- Reset mid-operation: all valids clear; wen_alu=0 on the next cycle; no partial writes.
- busy = OR of the S0..S4 valid bits.
- Address wrap or 0 has no special case; the address passes through unchanged.

Optional Feature:
- Macro: CONV_ALU_GRAY_OUT_EN.
- Defined: after S4 normalisation, gray Y = (R + 2G + B) >> 2 (4-bit), and wdata_alu = {Y,Y,Y}. This adds one register stage, so latency becomes 5.
- Undefined: per-channel RGB output at latency 4; no grayscale logic present.

Decomposition:
- Shared package/header holds:
  - mode encodings: MODE_IDENT, MODE_GAUSS, MODE_LAP, MODE_INV
  - 5x5 coefficient tables for Gaussian and Laplacian
  - accumulator width (13), pipeline latency constant
  - pixel channel bit ranges
- Sub-module conv_tap_sum: one 4-bit channel through S1–S4 (products, row sums, total, normalise), instantiated three times for R, G, B.
- Top-level conv_alu holds capture/dedup logic, address/valid pipeline and output registers.

Test Plan:
- Identity: mode=0, all taps 0x000 except centre 0xABC, raddr 1000, ren 1 cycle → single wen at capture+4, waddr 1000, wdata 0xABC.
- Gaussian flat: mode=1, all taps 0x777 → wdata 0x777. Then only the centre tap 0xF00, rest 0 → R=(36*15)>>8=2, so wdata 0x200.
- Laplacian: mode=2, uniform 0x555 → 0x000. Centre 0xF00, others 0 → 360 saturates, so 0xF00. Centre 0, others 0x00F → |-360| saturates, so 0x00F.
- Dedup/stream:
  - ren held 10 cycles at raddr 42 → exactly one wen.
  - raddr 0..7 on consecutive cycles → 8 consecutive wen pulses, waddr 0..7 in order.
  - ren low 1 cycle, then raddr 7 again → one more write.
- Reset/enable:
  - rst asserted 2 cycles after 3 captures → no wen, busy=0 the cycle after rst.
  - en=0 with ren active → no captures; windows captured before en fell still write.
- CONV_ALU_GRAY_OUT_EN build: mode=0, centre 0xF00 → wdata 0x333 at capture+5. Mode=3, centre 0x000 → 0xFFF.
